// File: rtl/coin_pkg.sv
// Shared types and constants for the coin acceptor front-end: channel and
// arbiter state encodings plus the {i,j} coin codes seen by the credit FSM.
package coin_pkg;

  typedef enum logic [2:0] {
    CH_WAIT_LOW = 3'd0,
    CH_IDLE     = 3'd1,
    CH_QUALIFY  = 3'd2,
    CH_HELD     = 3'd3,
    CH_JAM      = 3'd4
  } chan_state_t;

  typedef enum logic {
    ARB_READY = 1'b0,
    ARB_GAP   = 1'b1
  } arb_state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_ONE  = 2'b10;
  localparam logic [1:0] COIN_TWO  = 2'b11;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/coin_channel.sv
// One slot sensor: 2-flop synchroniser, then a debounce / jam-detect FSM that
// raises coin_event for one cycle when a coin is qualified.
module coin_channel
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JAM_CYCLES      = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic sense,
  output logic coin_event,
  output logic jammed
);

  localparam int CNT_MAX = (JAM_CYCLES > DEBOUNCE_CYCLES) ? JAM_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W   = cnt_width(CNT_MAX);
  localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] JAM_LIM = CNT_W'(JAM_CYCLES);

  logic             sync_p0, sync_p1;
  logic             vld_p0, vld_p1;
  logic             s;
  chan_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // Stage p0/p1: synchroniser; vld marks when the synced value reflects the
  // sensor rather than the reset contents, so WAIT_LOW cannot be fooled by a
  // coin sitting in the slot across reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      sync_p0 <= sense;
      sync_p1 <= sync_p0;
      vld_p0  <= 1'b1;
      vld_p1  <= vld_p0;
    end
  end

  assign s = sync_p1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= CH_WAIT_LOW;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    coin_event = 1'b0;
    case (state)
      CH_WAIT_LOW: begin
        if (vld_p1 && !s) state_nxt = CH_IDLE;
      end
      CH_IDLE: begin
        if (s) begin
          state_nxt = CH_QUALIFY;
          cnt_nxt   = CNT_W'(1);
        end
      end
      CH_QUALIFY: begin
        if (!s) begin
          state_nxt = CH_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LIM) begin
          state_nxt  = CH_HELD;
          cnt_nxt    = '0;
          coin_event = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      CH_HELD: begin
        if (!s) begin
          state_nxt = CH_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == JAM_LIM) begin
          state_nxt = CH_JAM;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      CH_JAM: begin
        if (!s) begin
          state_nxt = CH_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CH_WAIT_LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign jammed = (state == CH_JAM);

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front-end: two debounced sensor channels feeding per-channel
// pending counters, a fixed-priority arbiter with idle gap, and reject logic.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JAM_CYCLES      = 1000,
  parameter int GAP_CYCLES      = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic sense_one,
  input  logic sense_two,
  input  logic enable,
  output logic i,
  output logic j,
  output logic jam,
  output logic reject
);

  localparam int GAP_W = cnt_width(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic             evt_one, evt_two;
  logic             jam_one, jam_two;
  logic [1:0]       pend_one, pend_two;
  logic             strobe_one, strobe_two;
  logic             acc_one, acc_two;
  logic             rej_one, rej_two;
  arb_state_t       arb;
  logic [GAP_W-1:0] gap_cnt;

  // Saturating pending update; a simultaneous event and drain cancel out.
  function automatic logic [1:0] pend_update(input logic [1:0] cur,
                                             input logic inc,
                                             input logic dec);
    logic [1:0] r;
    r = cur;
    if (inc && !dec && cur != 2'd3) r = cur + 2'd1;
    else if (dec && !inc)           r = cur - 2'd1;
    return r;
  endfunction

  coin_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .JAM_CYCLES     (JAM_CYCLES)
  ) u_chan_one (
    .clock     (clock),
    .reset     (reset),
    .sense     (sense_one),
    .coin_event(evt_one),
    .jammed    (jam_one)
  );

  coin_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .JAM_CYCLES     (JAM_CYCLES)
  ) u_chan_two (
    .clock     (clock),
    .reset     (reset),
    .sense     (sense_two),
    .coin_event(evt_two),
    .jammed    (jam_two)
  );

  assign jam = jam_one | jam_two;

  // 1-rupee wins whenever both channels have coins waiting.
  assign strobe_one = (arb == ARB_READY) && (pend_one != 2'd0);
  assign strobe_two = (arb == ARB_READY) && (pend_one == 2'd0) && (pend_two != 2'd0);

  // A full counter still takes the event if it drains on the same edge.
  assign acc_one = evt_one && enable && ((pend_one != 2'd3) || strobe_one);
  assign acc_two = evt_two && enable && ((pend_two != 2'd3) || strobe_two);
  assign rej_one = evt_one && !acc_one;
  assign rej_two = evt_two && !acc_two;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_one <= 2'd0;
      pend_two <= 2'd0;
      reject   <= 1'b0;
    end else begin
      pend_one <= pend_update(pend_one, acc_one, strobe_one);
      pend_two <= pend_update(pend_two, acc_two, strobe_two);
      reject   <= rej_one | rej_two;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      arb     <= ARB_READY;
      gap_cnt <= '0;
      {i, j}  <= COIN_NONE;
    end else begin
      case (arb)
        ARB_READY: begin
          if (strobe_one || strobe_two) begin
            {i, j} <= strobe_one ? COIN_ONE : COIN_TWO;
            if (GAP_CYCLES > 0) begin
              arb     <= ARB_GAP;
              gap_cnt <= '0;
            end
          end else begin
            {i, j} <= COIN_NONE;
          end
        end
        ARB_GAP: begin
          {i, j} <= COIN_NONE;
          if (gap_cnt == GAP_LAST) arb <= ARB_READY;
          else                     gap_cnt <= gap_cnt + 1'b1;
        end
        default: begin
          arb    <= ARB_READY;
          {i, j} <= COIN_NONE;
        end
      endcase
    end
  end

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end for the coin-credit FSM that turns two raw, asynchronous slot sensors (1-rupee slot, 2-rupee slot) into clean, single-cycle coin strobes on `i` and `j`. The strobes are exactly what the credit FSM consumes:
- `i=1, j=0`: one rupee.
- `i=1, j=1`: two rupees.
- `i=0`: no coin this cycle.

The block synchronises and debounces each sensor, detects jams, buffers near-simultaneous coins and serialises them with a guaranteed idle gap.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synced-high cycles needed to accept a coin (≥1).
- `JAM_CYCLES`, default 1000: cycles a sensor may stay high after acceptance before it is declared jammed.
- `GAP_CYCLES`, default 1: idle cycles forced after every strobe (0 allows back-to-back strobes).
- `clock` input, 1 bit: clock.
- `reset` input, 1 bit: reset, asynchronous, active-high.
- `sense_one` input, 1 bit: raw 1-rupee slot sensor, asynchronous, high while a coin passes.
- `sense_two` input, 1 bit: raw 2-rupee slot sensor, same properties as `sense_one`.
- `enable` input, 1 bit: machine is accepting coins.
- `i` output, 1 bit: coin strobe, registered.
- `j` output, 1 bit: coin value (1 = two rupees), registered; valid only when `i=1`, otherwise 0.
- `jam` output, 1 bit: high while either channel is in JAM.
- `reject` output, 1 bit: one-cycle pulse for a coin accepted while `enable=0` or dropped on overflow.

## Operation
- **Synchronisation.** Each sensor passes through a 2-flop synchroniser. The synced value is `s`.
- **Channel FSM, one per sensor.** States WAIT_LOW, IDLE, QUALIFY, HELD, JAM.
  - WAIT_LOW: reset state. Goes to IDLE on the first `s=0`. This prevents a coin still present at reset from being counted.
  - IDLE: `s=1` moves to QUALIFY with `cnt=1`.
  - QUALIFY: `s=0` returns to IDLE (glitch, no event). If `s=1` and `cnt==DEBOUNCE_CYCLES`, move to HELD, clear `cnt` and raise the one-cycle internal event. Otherwise `cnt++`.
  - HELD: `s=0` goes to IDLE. If `s=1` and `cnt==JAM_CYCLES`, go to JAM; otherwise `cnt++`.
  - JAM: `s=0` goes to IDLE. No events are raised in JAM.
- **Event handling.** `enable` is sampled at the event edge.
  - `enable=1`: the channel's pending count increments (2-bit, saturates at 3). An event arriving while the count is already 3 is dropped and pulses `reject`.
  - `enable=0`: the event pulses `reject`; the pending count is unchanged.
  - Pending coins already accepted are still emitted after `enable` falls.
- **Output arbiter.** States READY, GAP.
  - READY: if `pend_one>0`, drive `i=1, j=0` and decrement `pend_one`. Otherwise, if `pend_two>0`, drive `i=1, j=1` and decrement `pend_two`. Otherwise `i=j=0`.
  - After any strobe: if `GAP_CYCLES>0`, go to GAP and hold `i=j=0` for exactly `GAP_CYCLES` cycles, then return to READY. If `GAP_CYCLES=0`, stay in READY.
  - 1-rupee has fixed priority.
- **Simultaneous events.**
  - Events from both channels on the same edge: both pending counts increment; the 1-rupee strobe is emitted first.
  - Event and decrement on the same channel in the same edge: the count is unchanged.
- **Reject.** One pulse per edge. Two reject causes on the same edge still give a single 1-cycle pulse.

## Timing
- **Reset values.** `i=0`, `j=0`, `jam=0`, `reject=0`. Synchronisers and counters are 0, channels are in WAIT_LOW, the arbiter is in READY. Reset mid-operation discards all pending coins.
- **Latency.** Let edge 1 be the first edge that samples the raw sensor high. With a channel in IDLE, the arbiter in READY and no pending coins:
  - the event occurs at edge `DEBOUNCE_CYCLES+3`;
  - `i` is high during the cycle after edge `DEBOUNCE_CYCLES+4`;
  - with the default `DEBOUNCE_CYCLES=4`, that is after edge 8.
- **Pulse widths.** `i` is high for exactly 1 cycle per coin. `reject` is a 1-cycle pulse coincident with the event edge + 1.
- **Jam.** `jam` rises the cycle after the HELD→JAM edge and falls the cycle after the sensor's synced low.

## Structure
- **Package `coin_pkg`:**
  - channel state enum (WAIT_LOW, IDLE, QUALIFY, HELD, JAM);
  - arbiter state enum (READY, GAP);
  - coin code constants `COIN_NONE=2'b00`, `COIN_ONE=2'b10`, `COIN_TWO=2'b11`, mapped to `{i,j}`.
- **Sub-module `coin_channel`:** synchroniser, debounce/jam FSM and counter. Outputs `event` and `jammed`. Instantiated twice.
- **Top level:** pending counters, arbiter and reject logic.

## Test plan
- Clean 1-rupee pulse: `sense_one` high for 10 cycles, `enable=1`, defaults → exactly one `i=1, j=0` after edge 8; `reject` stays 0.
- Glitch: `sense_two` high for 3 cycles (`DEBOUNCE_CYCLES=4`) → no strobe, no reject.
- Both sensors rise on the same edge with `GAP_CYCLES=1` → `{i,j}` is 10, then 00, then 11 on three consecutive cycles.
- Jam: `JAM_CYCLES=20`, `sense_one` held high for 40 cycles → one strobe, then `jam=1` from roughly cycle 28 until 3 cycles after release.
- `enable=0` with a 2-rupee coin → one `reject` pulse, no strobe. Then `sense_one` is held high across reset deassertion → no strobe until the sensor goes low and a fresh coin arrives.
